// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB register slave: read-only ID word, R/W register bank, wait states, error response.
// Optional per-byte write strobes are enabled by defining APB_REG_SLAVE_PSTRB_EN.
module apb_reg_slave #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5F7_0006
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psel,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [31:0]              PADDR,
  input  logic [31:0]              PWDATA,
`ifdef APB_REG_SLAVE_PSTRB_EN
  input  logic [3:0]               PSTRB,
`endif
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [32*NUM_REGS-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      wr_pulse,
  output logic                     proto_err,
  input  logic                     proto_err_clr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [7:0]  lat_idx;
  logic        lat_write;
  logic [31:0] lat_wdata;
  logic        lat_err;
  logic [3:0]  lat_strb;
  logic [31:0] regs [1:NUM_REGS-1];

  logic        do_setup, do_commit, do_abort, do_lone, do_dec;
  logic [7:0]  in_idx;
  logic        in_err;
  logic [3:0]  in_strb;
  logic [31:0] rd_word;

  wire unused_paddr = ^{PADDR[31:10], PADDR[1:0]};

  assign in_idx = PADDR[9:2];

`ifdef APB_REG_SLAVE_PSTRB_EN
  assign in_strb = PSTRB;
  assign in_err  = ({1'b0, in_idx} >= 9'(NUM_REGS)) || (PWRITE && in_idx == 8'd0) ||
                   (!PWRITE && PSTRB != 4'd0);
`else
  assign in_strb = 4'hF;
  assign in_err  = ({1'b0, in_idx} >= 9'(NUM_REGS)) || (PWRITE && in_idx == 8'd0);
`endif

  always_comb begin
    rd_word = (in_idx == 8'd0) ? ID_VALUE : 32'd0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (in_idx == 8'(i)) rd_word = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_setup  = 1'b0;
    do_commit = 1'b0;
    do_abort  = 1'b0;
    do_lone   = 1'b0;
    do_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !PENABLE) begin
          do_setup  = 1'b1;
          state_nxt = ACCESS;
        end else if (psel && PENABLE) begin
          do_lone = 1'b1;
        end
      end
      ACCESS: begin
        if (psel && PENABLE) begin
          if (cnt == 4'd0) begin
            do_commit = 1'b1;
            state_nxt = IDLE;
          end else begin
            do_dec = 1'b1;
          end
        end else begin
          // An aborted access never doubles as a fresh setup phase.
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign PREADY  = (state == ACCESS) && (cnt == 4'd0);
  assign PSLVERR = lat_err && PREADY;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      lat_idx   <= 8'd0;
      lat_write <= 1'b0;
      lat_wdata <= 32'd0;
      lat_err   <= 1'b0;
      lat_strb  <= 4'd0;
      PRDATA    <= 32'd0;
    end else if (do_setup) begin
      cnt       <= 4'(WAIT_STATES);
      lat_idx   <= in_idx;
      lat_write <= PWRITE;
      lat_wdata <= PWDATA;
      lat_err   <= in_err;
      lat_strb  <= in_strb;
      if (!PWRITE) PRDATA <= in_err ? 32'd0 : rd_word;
    end else if (do_dec) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pulse <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else begin
      wr_pulse <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (do_commit && lat_write && !lat_err && lat_idx == 8'(i)) begin
          wr_pulse[i] <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (lat_strb[b]) regs[i][8*b +: 8] <= lat_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      proto_err <= 1'b0;
    else if (do_lone || do_abort) proto_err <= 1'b1;
    else if (proto_err_clr)       proto_err <= 1'b0;
  end

  always_comb begin
    regs_out[31:0] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) regs_out[32*i +: 32] = regs[i];
  end

endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
- APB completer (responder) at the peripheral end of the AHB-to-APB path. It decodes one select line from the bridge and serves a bank of 32-bit software registers.
- Register 0 is a read-only ID word. Registers 1..NUM_REGS-1 are read/write, exported to hardware, and each has a one-cycle write pulse.
- Configurable access-phase wait states via PREADY. Error response on bad accesses.
- WAIT_STATES=0 gives zero-wait timing: PRDATA is valid in the first access cycle.

Parameters:
- NUM_REGS, 8, number of 32-bit registers including ID register 0; range 2..256.
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion; range 0..15.
- ID_VALUE, 32'hA5F7_0006, constant returned by register 0.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- psel  input  1  APB select from bridge.
- PENABLE  input  1  APB access-phase indicator.
- PWRITE  input  1  1=write, 0=read.
- PADDR  input  32  byte address; PADDR[9:2] = register index; other bits ignored.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data, registered.
- PREADY  output  1  transfer completes this cycle.
- PSLVERR  output  1  error response, meaningful only when PREADY=1.
- regs_out  output  32*NUM_REGS  flattened register contents; slice 0 = ID_VALUE.
- wr_pulse  output  NUM_REGS  one-cycle pulse per register on committed write; bit 0 always 0.
- proto_err  output  1  sticky protocol-violation flag.
- proto_err_clr  input  1  clears proto_err.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, regs 1..N-1=0, PRDATA=0, PREADY=0, PSLVERR=0, wr_pulse=0, proto_err=0, wait counter=0. Reset wins over any in-flight transfer; no write commits on the reset edge.
- FSM states: IDLE and ACCESS. A 4-bit wait counter runs inside ACCESS.
- IDLE, setup phase (psel=1, PENABLE=0):
  - At the edge: latch index, PWRITE, PWDATA and the error condition.
  - Load counter=WAIT_STATES.
  - If read: PRDATA <= selected register, or 0 on error.
  - Go to ACCESS.
- IDLE with psel=1, PENABLE=1 (no setup seen): ignore, set proto_err, stay IDLE.
- ACCESS outputs:
  - PREADY = (counter==0), combinational from state and counter.
  - PSLVERR = latched error AND PREADY.
- ACCESS with psel=1, PENABLE=1, counter!=0: decrement counter, stay in ACCESS.
- ACCESS with psel=1, PENABLE=1, counter==0: transfer completes.
  - Non-error write: commit to the register at this edge.
  - wr_pulse[index]=1 in the following cycle only.
  - Next state IDLE. A back-to-back setup in the next cycle is accepted normally, so zero-wait throughput is 2 cycles per transfer.
- ACCESS with psel=0 or PENABLE=0 (abort):
  - No write commits; go to IDLE; set proto_err.
  - If psel=1 and PENABLE=0, that cycle is not treated as a new setup.
- Latched inputs: PADDR, PWRITE and PWDATA changes during ACCESS are ignored; the values latched at setup are used.
- Error condition (PSLVERR=1): index >= NUM_REGS, or write to index 0. On error, writes are dropped and reads return 0.
- PREADY=0 and PSLVERR=0 in IDLE. PRDATA holds its last value except on read setup.
- proto_err clear priority: set > clear if both occur in the same cycle.
- wr_pulse is held at 0 except as above. Simultaneous wr_pulse and a new setup are allowed.

Optional Feature:
- Macro: APB_REG_SLAVE_PSTRB_EN.
- Enabled:
  - Adds input PSTRB [3:0], latched at setup.
  - A committed write updates only the bytes whose strobe bit is 1.
  - PSTRB=0 on a write still pulses wr_pulse with no data change.
  - Read with PSTRB!=0 gives PSLVERR=1.
- Disabled: no PSTRB port; every write updates all 32 bits.

Test Plan:
- Reset, then zero-wait read of index 0 (PADDR=0x8000_0000) -> PRDATA=0xA5F70006 in first access cycle, PREADY=1, PSLVERR=0.
- Write 0xDEADBEEF to index 3 (PADDR=0x8000_000C) -> regs_out slice 3 = 0xDEADBEEF after access edge; wr_pulse=8'b0000_1000 for exactly one cycle; readback matches.
- WAIT_STATES=3, read index 3 -> PREADY low for 3 access cycles, high on 4th; PRDATA stable at 0xDEADBEEF throughout.
- Write to index 9 (NUM_REGS=8) and write to index 0 -> PSLVERR=1 with PREADY=1; no regs_out change, no wr_pulse. Read of index 9 -> PRDATA=0, PSLVERR=1.
- WAIT_STATES=2, write 0x1234 to index 2, drop psel in 2nd access cycle -> reg 2 unchanged, proto_err=1. proto_err_clr -> 0. Lone PENABLE without setup -> proto_err=1.
- Back-to-back zero-wait write then read of index 5 -> both complete in 4 cycles total. With APB_REG_SLAVE_PSTRB_EN, PSTRB=4'b0010, PWDATA=0xFFFFFFFF over 0 -> reg=0x0000FF00.
